// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR              = 32'h00000013;
    localparam logic [3:0]  EXC_INSTR_MISALIGNED   = 4'd0;
    localparam logic [3:0]  EXC_INSTR_ACCESS_FAULT = 4'd1;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;
    localparam int CODE_W  = 4;
    localparam int TVAL_W  = 64;
    localparam int ENTRY_W = PC_W + INSTR_W + 1 + CODE_W + TVAL_W;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FAULT = 1'b1
    } state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               exc_en;
        logic [CODE_W-1:0]  exc_code;
        logic [TVAL_W-1:0]  exc_val;
    } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; a push into a full FIFO is accepted
// when a pop happens in the same cycle. Flush overrides push and pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(DEPTH));
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
            else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && push_ok) mem_q[wr_ptr_q] <= din;
    end

    assign dout = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, buffers {pc, instr, exc}
// entries for decode, and parks after a fault until the next redirect.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    output logic [63:0] imem_pc_addr,
    input  logic [31:0] imem_instruction,
    input  logic        imem_exc_en,
    input  logic [3:0]  imem_exc_code,
    input  logic [63:0] imem_exc_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_exc_en,
    output logic [3:0]  out_exc_code,
    output logic [63:0] out_exc_val
);

    logic [63:0] pc_q, pc_d;
    state_e      state_q, state_d;
    logic        misalign_q, misalign_d;
    logic        push, pop;
    logic        fifo_full, fifo_empty;
    entry_t      push_entry, head_entry, shown_entry;

    always_comb begin
        pc_d       = pc_q;
        state_d    = state_q;
        misalign_d = misalign_q;
        push       = 1'b0;
        push_entry = '0;
        pop        = !fifo_empty && out_ready;
        if (redirect_en) begin
            pc_d       = redirect_pc;
            state_d    = ST_FETCH;
            misalign_d = |redirect_pc[1:0];
        end else if (fetch_en && state_q == ST_FETCH && (!fifo_full || pop)) begin
            push = 1'b1;
            // A misaligned target is reported without looking at imem.
            if (misalign_q) begin
                push_entry = '{pc_q, NOP_INSTR, 1'b1, EXC_INSTR_MISALIGNED, pc_q};
                state_d    = ST_FAULT;
                misalign_d = 1'b0;
            end else if (imem_exc_en) begin
                push_entry = '{pc_q, NOP_INSTR, 1'b1, imem_exc_code, imem_exc_val};
                state_d    = ST_FAULT;
            end else begin
                push_entry = '{pc_q, imem_instruction, 1'b0, 4'd0, 64'd0};
                pc_d       = pc_q + 64'd4;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            state_q    <= ST_FETCH;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            state_q    <= state_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_en),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Storage is not reset, so an empty FIFO presents all-zero fields.
    assign shown_entry  = fifo_empty ? '0 : head_entry;
    assign out_valid    = !fifo_empty;
    assign out_pc       = shown_entry.pc;
    assign out_instr    = shown_entry.instr;
    assign out_exc_en   = shown_entry.exc_en;
    assign out_exc_code = shown_entry.exc_code;
    assign out_exc_val  = shown_entry.exc_val;
    assign imem_pc_addr = pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a queue of expected decode-side entries.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic [63:0] imem_pc_addr;
    logic [31:0] imem_instruction;
    logic        imem_exc_en;
    logic [3:0]  imem_exc_code;
    logic [63:0] imem_exc_val;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exc_en;
    logic [3:0]  out_exc_code;
    logic [63:0] out_exc_val;

    int checks = 0;
    int errors = 0;
    logic [164:0] exp_q [$];
    logic [164:0] head;

    fetch_ctrl #(
        .RESET_PC   (64'h0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_en         (fetch_en),
        .redirect_en      (redirect_en),
        .redirect_pc      (redirect_pc),
        .imem_pc_addr     (imem_pc_addr),
        .imem_instruction (imem_instruction),
        .imem_exc_en      (imem_exc_en),
        .imem_exc_code    (imem_exc_code),
        .imem_exc_val     (imem_exc_val),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .out_instr        (out_instr),
        .out_exc_en       (out_exc_en),
        .out_exc_code     (out_exc_code),
        .out_exc_val      (out_exc_val)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0003;
    endfunction

    function automatic logic [164:0] ok_e(input logic [63:0] pc);
        return {pc, instr_of(pc), 1'b0, 4'd0, 64'd0};
    endfunction

    function automatic logic [164:0] exc_e(input logic [63:0] pc, input logic [3:0] code,
                                           input logic [63:0] val);
        return {pc, 32'h00000013, 1'b1, code, val};
    endfunction

    assign imem_instruction = instr_of(imem_pc_addr);
    assign head = {out_pc, out_instr, out_exc_en, out_exc_code, out_exc_val};

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ent(input string tag, input logic [164:0] obs, input logic [164:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_pop(input string tag);
        logic [164:0] e;
        chk_bit({tag, "_valid"}, out_valid, 1'b1);
        chk_bit({tag, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk_ent(tag, head, e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        fetch_en      = 1'b1;
        redirect_en   = 1'b0;
        redirect_pc   = 64'h0;
        imem_exc_en   = 1'b0;
        imem_exc_code = 4'd0;
        imem_exc_val  = 64'h0;
        out_ready     = 1'b1;
        repeat (3) tick();
        chk_bit("rst_valid", out_valid, 1'b0);
        chk_64("rst_pc_addr", imem_pc_addr, 64'h0);
        chk_ent("rst_out_fields", head, '0);

        // Streaming from reset
        rst = 1'b0;
        exp_q.push_back(ok_e(64'h0));
        exp_q.push_back(ok_e(64'h4));
        exp_q.push_back(ok_e(64'h8));
        chk_bit("a_first_cycle_empty", out_valid, 1'b0);
        tick();
        expect_pop("a_pop0");
        tick();
        expect_pop("a_pop4");
        tick();
        expect_pop("a_pop8");
        tick();
        #1 rst = 1'b1;
        #1;
        chk_bit("a_midrst_valid", out_valid, 1'b0);
        chk_64("a_midrst_pc", imem_pc_addr, 64'h0);
        chk_ent("a_midrst_fields", head, '0);
        chk_bit("a_sb_drained", exp_q.size() == 0, 1'b1);
        tick();

        // Backpressure fills the FIFO, then drains without gap or duplicate
        rst = 1'b0;
        out_ready = 1'b0;
        exp_q.push_back(ok_e(64'h0));
        exp_q.push_back(ok_e(64'h4));
        exp_q.push_back(ok_e(64'h8));
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) chk_64("b_hold_addr", imem_pc_addr, 64'h8);
            tick();
        end
        chk_bit("b_full_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        expect_pop("b_pop0");
        tick();
        expect_pop("b_pop4");
        tick();
        expect_pop("b_pop8");
        tick();

        // Redirect discards a full FIFO
        out_ready = 1'b0;
        tick();
        redirect_en = 1'b1;
        redirect_pc = 64'h100;
        out_ready   = 1'b1;
        tick();
        redirect_en = 1'b0;
        chk_64("c_addr_target", imem_pc_addr, 64'h100);
        chk_bit("c_flushed", out_valid, 1'b0);
        exp_q.push_back(ok_e(64'h100));
        tick();
        expect_pop("c_pop100");
        tick();

        // Access fault parks fetch until a redirect
        redirect_en = 1'b1;
        redirect_pc = 64'h2000;
        tick();
        redirect_en   = 1'b0;
        imem_exc_en   = 1'b1;
        imem_exc_code = 4'd1;
        imem_exc_val  = 64'h2000;
        chk_64("d_addr_fault", imem_pc_addr, 64'h2000);
        exp_q.push_back(exc_e(64'h2000, 4'd1, 64'h2000));
        tick();
        imem_exc_en = 1'b0;
        expect_pop("d_exc_entry");
        tick();
        for (int i = 0; i < 4; i++) begin
            imem_exc_en = (i % 2 == 0);
            chk_bit("d_parked_valid", out_valid, 1'b0);
            chk_64("d_parked_addr", imem_pc_addr, 64'h2000);
            tick();
        end
        imem_exc_en = 1'b0;
        redirect_en = 1'b1;
        redirect_pc = 64'h40;
        tick();
        redirect_en = 1'b0;
        chk_64("d_resume_addr", imem_pc_addr, 64'h40);
        exp_q.push_back(ok_e(64'h40));
        exp_q.push_back(ok_e(64'h44));
        tick();
        expect_pop("d_pop40");
        tick();
        expect_pop("d_pop44");
        tick();

        // Misaligned redirect target
        redirect_en = 1'b1;
        redirect_pc = 64'h102;
        tick();
        redirect_en = 1'b0;
        chk_64("e_addr", imem_pc_addr, 64'h102);
        chk_bit("e_flushed", out_valid, 1'b0);
        exp_q.push_back(exc_e(64'h102, 4'd0, 64'h102));
        tick();
        expect_pop("e_misalign_entry");
        tick();
        for (int i = 0; i < 2; i++) begin
            chk_bit("e_parked_valid", out_valid, 1'b0);
            chk_64("e_parked_addr", imem_pc_addr, 64'h102);
            tick();
        end

        // Redirect coinciding with an imem fault
        redirect_en = 1'b1;
        redirect_pc = 64'h200;
        tick();
        chk_64("f_addr200", imem_pc_addr, 64'h200);
        redirect_pc   = 64'h300;
        imem_exc_en   = 1'b1;
        imem_exc_code = 4'd1;
        imem_exc_val  = 64'h200;
        tick();
        redirect_en = 1'b0;
        imem_exc_en = 1'b0;
        chk_64("f_addr300", imem_pc_addr, 64'h300);
        chk_bit("f_no_exc_entry", out_valid, 1'b0);
        exp_q.push_back(ok_e(64'h300));
        exp_q.push_back(ok_e(64'h304));
        tick();
        expect_pop("f_pop300");
        tick();
        expect_pop("f_pop304");
        tick();
        #1 rst = 1'b1;
        #1;
        chk_bit("f_midrst_valid", out_valid, 1'b0);
        chk_64("f_midrst_pc", imem_pc_addr, 64'h0);
        chk_ent("f_midrst_fields", head, '0);
        tick();

        // Fetch disabled holds the PC but still honours a redirect
        rst = 1'b0;
        fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_bit("g_disabled_valid", out_valid, 1'b0);
            chk_64("g_disabled_addr", imem_pc_addr, 64'h0);
            tick();
        end
        redirect_en = 1'b1;
        redirect_pc = 64'h80;
        tick();
        redirect_en = 1'b0;
        chk_64("g_redirect_addr", imem_pc_addr, 64'h80);
        tick();
        chk_bit("g_still_empty", out_valid, 1'b0);
        chk_64("g_hold_addr", imem_pc_addr, 64'h80);
        fetch_en = 1'b1;
        exp_q.push_back(ok_e(64'h80));
        tick();
        expect_pop("g_pop80");
        chk_bit("g_sb_drained", exp_q.size() == 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
